ex_wb_skid_stage: RTL and testbench

Parametrised EX→WB pipeline stage register with valid/ready handshake and a two-entry skid buffer. It carries the ALU result, destination register index and write-enable from execute to writeback. Unlike a free-running stage register, it supports writeback-side stalls without bubbles or data loss, synchronous flush, x0-write suppression and a saturating stall counter for performance debug.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/ex_wb_skid_stage_if.sv | 32 +++
 rtl/stage_entry_reg.sv | 39 +++
 rtl/ex_wb_skid_stage.sv | 163 ++++++++++++++++
 tb/tb_ex_wb_skid_stage.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the EX->WB pipeline stage.
// The payload struct describes one stage entry at the default widths.
package pipeline_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RD_WIDTH   = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] alu_result;
        logic [DEF_RD_WIDTH-1:0]   rd;
        logic                      reg_write;
    } payload_t;

endpackage

// File: rtl/ex_wb_skid_stage_if.sv
// Valid/ready channel pair between execute and writeback.
// The master side is the surrounding pipeline; the slave side is the stage.
interface ex_wb_skid_stage_if
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_WIDTH   = DEF_RD_WIDTH
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_alu_result;
    logic [RD_WIDTH-1:0]   in_rd;
    logic                  in_reg_write;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_alu_result;
    logic [RD_WIDTH-1:0]   out_rd;
    logic                  out_reg_write;

    modport master (
        output in_valid, in_alu_result, in_rd, in_reg_write, out_ready,
        input  in_ready, out_valid, out_alu_result, out_rd, out_reg_write
    );

    modport slave (
        input  in_valid, in_alu_result, in_rd, in_reg_write, out_ready,
        output in_ready, out_valid, out_alu_result, out_rd, out_reg_write
    );

endinterface

// File: rtl/stage_entry_reg.sv
// Load-enabled payload register with asynchronous clear.
// Used for both the main (head) entry and the skid entry.
module stage_entry_reg
    import pipeline_pkg::*;
#(
    parameter int WIDTH = $bits(payload_t)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Capture a new payload only when loaded; otherwise hold.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = d_i;
        end else begin
            data_d = data_q;
        end
    end

    // Payload storage, cleared to zero on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= {WIDTH{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_wb_skid_stage.sv
// EX->WB stage register with a two-entry skid buffer, flush, x0 write
// suppression and a saturating stall counter.
module ex_wb_skid_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int RD_WIDTH    = DEF_RD_WIDTH,
    parameter bit SUPPRESS_X0 = 1'b1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    ex_wb_skid_stage_if.slave      pipe,
    output logic [1:0]             occupancy,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu_result;
        logic [RD_WIDTH-1:0]   rd;
        logic                  reg_write;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    localparam logic [1:0] S_EMPTY = ST_EMPTY;
    localparam logic [1:0] S_ONE   = ST_ONE;
    localparam logic [1:0] S_FULL  = ST_FULL;

    // Writes to x0 are architecturally dead, so they never reach WB.
    function automatic logic gate_x0(input logic we, input logic [RD_WIDTH-1:0] rd);
        return we & ~(SUPPRESS_X0 & (rd == {RD_WIDTH{1'b0}}));
    endfunction

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [COUNT_WIDTH-1:0] stall_q;
    logic [COUNT_WIDTH-1:0] stall_d;
    logic                   in_fire_s;
    logic                   out_fire_s;
    logic                   load_main_s;
    logic                   load_skid_s;
    logic                   main_from_skid_s;
    entry_t                 in_entry_s;
    entry_t                 main_d_s;
    entry_t                 main_q_s;
    entry_t                 skid_q_s;

    assign pipe.in_ready = (state_q != S_FULL);
    assign pipe.out_valid = (state_q != S_EMPTY);
    assign in_fire_s  = pipe.in_valid & pipe.in_ready;
    assign out_fire_s = pipe.out_valid & pipe.out_ready;

    // Incoming payload with the write-enable already gated for x0.
    always_comb begin
        in_entry_s            = '{alu_result: {DATA_WIDTH{1'b0}}, rd: {RD_WIDTH{1'b0}}, reg_write: 1'b0};
        in_entry_s.alu_result = pipe.in_alu_result;
        in_entry_s.rd         = pipe.in_rd;
        in_entry_s.reg_write  = gate_x0(pipe.in_reg_write, pipe.in_rd);
    end

    // Occupancy FSM; flush empties the stage without touching stored payloads.
    always_comb begin
        state_d          = state_q;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire_s) begin
                        state_d     = S_ONE;
                        load_main_s = 1'b1;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
                S_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        state_d     = S_ONE;
                        load_main_s = 1'b1;
                    end else if (in_fire_s) begin
                        state_d     = S_FULL;
                        load_skid_s = 1'b1;
                    end else if (out_fire_s) begin
                        state_d = S_EMPTY;
                    end else begin
                        state_d = S_ONE;
                    end
                end
                S_FULL: begin
                    if (out_fire_s) begin
                        state_d          = S_ONE;
                        load_main_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_d = S_FULL;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // Head entry refills from the skid when draining out of FULL.
    always_comb begin
        main_d_s = in_entry_s;
        if (main_from_skid_s) begin
            main_d_s = skid_q_s;
        end else begin
            main_d_s = in_entry_s;
        end
    end

    // Saturating count of cycles where WB back-pressures a valid entry.
    always_comb begin
        stall_d = stall_q;
        if (pipe.out_valid && !pipe.out_ready && (stall_q != {COUNT_WIDTH{1'b1}})) begin
            stall_d = stall_q + COUNT_WIDTH'(1'b1);
        end else begin
            stall_d = stall_q;
        end
    end

    // Control state and stall counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_EMPTY;
            stall_q <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    stage_entry_reg #(.WIDTH(ENTRY_W)) u_main (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .load_i (load_main_s),
        .d_i    (main_d_s),
        .q_o    (main_q_s)
    );

    stage_entry_reg #(.WIDTH(ENTRY_W)) u_skid (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .load_i (load_skid_s),
        .d_i    (in_entry_s),
        .q_o    (skid_q_s)
    );

    assign pipe.out_alu_result = main_q_s.alu_result;
    assign pipe.out_rd         = main_q_s.rd;
    assign pipe.out_reg_write  = pipe.out_valid & main_q_s.reg_write;
    assign occupancy           = state_q;
    assign stall_count         = stall_q;

endmodule

// File: tb/tb_ex_wb_skid_stage.sv
// Scoreboard bench for ex_wb_skid_stage: two instances share stimulus, one
// with x0 suppression and one without; both use a 4-bit stall counter.
module tb_ex_wb_skid_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    typedef struct {
        logic [DW-1:0] alu;
        logic [RW-1:0] rd;
        logic          we_a;
        logic          we_b;
    } exp_t;

    logic          clock     = 1'b0;
    logic          reset_n   = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_alu    = 32'h0;
    logic [RW-1:0] in_rd     = 5'd0;
    logic          in_we     = 1'b0;
    logic          out_ready = 1'b0;

    logic [1:0]    occ_a;
    logic [1:0]    occ_b;
    logic [CW-1:0] stall_a;
    logic [CW-1:0] stall_b;

    exp_t          exp_q[$];
    logic [1:0]    m_occ   = 2'd0;
    logic [CW-1:0] m_stall = 4'd0;
    int            checks  = 0;
    int            errors  = 0;

    ex_wb_skid_stage_if #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) if_a ();
    ex_wb_skid_stage_if #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) if_b ();

    assign if_a.in_valid      = in_valid;
    assign if_a.in_alu_result = in_alu;
    assign if_a.in_rd         = in_rd;
    assign if_a.in_reg_write  = in_we;
    assign if_a.out_ready     = out_ready;
    assign if_b.in_valid      = in_valid;
    assign if_b.in_alu_result = in_alu;
    assign if_b.in_rd         = in_rd;
    assign if_b.in_reg_write  = in_we;
    assign if_b.out_ready     = out_ready;

    ex_wb_skid_stage #(.DATA_WIDTH(DW), .RD_WIDTH(RW), .SUPPRESS_X0(1'b1), .COUNT_WIDTH(CW)) dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .pipe        (if_a),
        .occupancy   (occ_a),
        .stall_count (stall_a)
    );

    ex_wb_skid_stage #(.DATA_WIDTH(DW), .RD_WIDTH(RW), .SUPPRESS_X0(1'b0), .COUNT_WIDTH(CW)) dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .pipe        (if_b),
        .occupancy   (occ_b),
        .stall_count (stall_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, then return just after the sampling edge.
    task automatic cycle(input logic v, input logic [DW-1:0] alu, input logic [RW-1:0] rd,
                         input logic we, input logic ordy, input logic fl);
        in_valid  = v;
        in_alu    = alu;
        in_rd     = rd;
        in_we     = we;
        out_ready = ordy;
        flush     = fl;
        @(posedge clock);
        #1;
    endtask

    // Reference model: pushes accepted entries, retires consumed ones.
    initial begin : model
        logic in_fire;
        logic out_fire;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_occ   = 2'd0;
                m_stall = 4'd0;
                exp_q.delete();
            end else begin
                in_fire  = in_valid && (m_occ != 2'd2);
                out_fire = (m_occ != 2'd0) && out_ready;
                if ((m_occ != 2'd0) && !out_ready && (m_stall != 4'hF)) begin
                    m_stall = m_stall + 4'd1;
                end
                if (flush) begin
                    exp_q.delete();
                    m_occ = 2'd0;
                end else begin
                    if (out_fire && (exp_q.size() > 0)) begin
                        exp_q.delete(0);
                        m_occ = m_occ - 2'd1;
                    end
                    if (in_fire) begin
                        exp_q.push_back('{in_alu, in_rd, in_we && (in_rd != 5'd0), in_we});
                        m_occ = m_occ + 2'd1;
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model on every falling edge.
    initial begin : monitor
        forever begin
            @(negedge clock);
            check("occupancy_a", 64'(occ_a), 64'(m_occ));
            check("occupancy_b", 64'(occ_b), 64'(m_occ));
            check("in_ready", 64'(if_a.in_ready), 64'(m_occ != 2'd2));
            check("out_valid", 64'(if_a.out_valid), 64'(m_occ != 2'd0));
            check("stall_count", 64'(stall_a), 64'(m_stall));
            if (m_occ != 2'd0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty actual=valid required=no_entry at %0t", $time);
                end else begin
                    check("out_alu_result", 64'(if_a.out_alu_result), 64'(exp_q[0].alu));
                    check("out_rd", 64'(if_a.out_rd), 64'(exp_q[0].rd));
                    check("out_reg_write_a", 64'(if_a.out_reg_write), 64'(exp_q[0].we_a));
                    check("out_reg_write_b", 64'(if_b.out_reg_write), 64'(exp_q[0].we_b));
                    check("out_alu_result_b", 64'(if_b.out_alu_result), 64'(exp_q[0].alu));
                end
            end else begin
                check("out_reg_write_idle", 64'(if_a.out_reg_write), 64'(1'b0));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        // Reset state.
        @(posedge clock);
        #2;
        check("rst_occupancy", 64'(occ_a), 64'(2'd0));
        check("rst_in_ready", 64'(if_a.in_ready), 64'(1'b1));
        check("rst_out_alu", 64'(if_a.out_alu_result), 64'(32'h0));
        check("rst_out_rd", 64'(if_a.out_rd), 64'(5'd0));
        @(negedge clock);
        #2;
        reset_n = 1'b1;

        // Back-to-back stream with WB always ready.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h11 * 32'(i + 1), 5'(i + 1), 1'b1, 1'b1, 1'b0);
            check("stream_occ", 64'(occ_a), 64'(2'd1));
            check("stream_alu", 64'(if_a.out_alu_result), 64'(32'h11 * 32'(i + 1)));
        end
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("stream_stall", 64'(stall_a), 64'(4'd0));

        // Skid absorption: WB stalls for three cycles.
        cycle(1'b1, 32'h11, 5'd1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h22, 5'd2, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h33, 5'd3, 1'b1, 1'b0, 1'b0);
        check("skid_full_occ", 64'(occ_a), 64'(2'd2));
        check("skid_full_ready", 64'(if_a.in_ready), 64'(1'b0));
        cycle(1'b1, 32'h44, 5'd4, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h44, 5'd4, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h44, 5'd4, 1'b1, 1'b1, 1'b0);
        check("skid_release_alu", 64'(if_a.out_alu_result), 64'(32'h33));
        cycle(1'b1, 32'h44, 5'd4, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("skid_stall_count", 64'(stall_a), 64'(4'd3));

        // x0 write suppression versus pass-through.
        cycle(1'b1, 32'h55, 5'd0, 1'b1, 1'b1, 1'b0);
        check("x0_valid", 64'(if_a.out_valid), 64'(1'b1));
        check("x0_suppressed", 64'(if_a.out_reg_write), 64'(1'b0));
        check("x0_kept", 64'(if_b.out_reg_write), 64'(1'b1));
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Flush while FULL with a new entry presented.
        cycle(1'b1, 32'h66, 5'd6, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h77, 5'd7, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h88, 5'd8, 1'b1, 1'b0, 1'b1);
        check("flush_occ", 64'(occ_a), 64'(2'd0));
        check("flush_valid", 64'(if_a.out_valid), 64'(1'b0));
        check("flush_reg_write", 64'(if_a.out_reg_write), 64'(1'b0));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        end

        // Asynchronous reset while FULL.
        cycle(1'b1, 32'h99, 5'd9, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h9A, 5'd10, 1'b1, 1'b0, 1'b0);
        check("pre_reset_full", 64'(occ_a), 64'(2'd2));
        #2;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("arst_occ", 64'(occ_a), 64'(2'd0));
        check("arst_valid", 64'(if_a.out_valid), 64'(1'b0));
        check("arst_reg_write", 64'(if_a.out_reg_write), 64'(1'b0));
        check("arst_alu", 64'(if_a.out_alu_result), 64'(32'h0));
        check("arst_rd", 64'(if_a.out_rd), 64'(5'd0));
        check("arst_stall", 64'(stall_a), 64'(4'd0));
        check("arst_in_ready", 64'(if_a.in_ready), 64'(1'b1));
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        cycle(1'b1, 32'hAA, 5'd10, 1'b1, 1'b1, 1'b0);
        check("post_reset_valid", 64'(if_a.out_valid), 64'(1'b1));
        check("post_reset_alu", 64'(if_a.out_alu_result), 64'(32'hAA));
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Stall counter saturation.
        cycle(1'b1, 32'hBB, 5'd11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 21; i++) begin
            cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        end
        check("stall_saturate_a", 64'(stall_a), 64'(4'hF));
        check("stall_saturate_b", 64'(stall_b), 64'(4'hF));
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("drain_empty", 64'(occ_a), 64'(2'd0));

        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
